// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mc_ctrl_pkg
//  Description : Shared definitions for the multicycle MIPS main control:
//                state encodings, supported opcodes, datapath select
//                encodings and the packed control word produced by the
//                state decoder.
//  Revision    : 1.0  initial release
// ============================================================================
package mc_ctrl_pkg;

    localparam int c_STATE_W = 4;

    // State encodings (12 of 16 codes used; the remainder are unreachable)
    localparam logic [c_STATE_W-1:0] c_ST_FETCH  = 4'd0;
    localparam logic [c_STATE_W-1:0] c_ST_DECODE = 4'd1;
    localparam logic [c_STATE_W-1:0] c_ST_MEMADR = 4'd2;
    localparam logic [c_STATE_W-1:0] c_ST_MEMRD  = 4'd3;
    localparam logic [c_STATE_W-1:0] c_ST_MEMWB  = 4'd4;
    localparam logic [c_STATE_W-1:0] c_ST_MEMWR  = 4'd5;
    localparam logic [c_STATE_W-1:0] c_ST_EXEC   = 4'd6;
    localparam logic [c_STATE_W-1:0] c_ST_RWB    = 4'd7;
    localparam logic [c_STATE_W-1:0] c_ST_BRANCH = 4'd8;
    localparam logic [c_STATE_W-1:0] c_ST_JUMP   = 4'd9;
    localparam logic [c_STATE_W-1:0] c_ST_ADDIEX = 4'd10;
    localparam logic [c_STATE_W-1:0] c_ST_ADDIWB = 4'd11;

    // Supported opcodes (instr[31:26])
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;

    // ALU B-operand select
    localparam logic [1:0] c_SRCB_B      = 2'b00;
    localparam logic [1:0] c_SRCB_FOUR   = 2'b01;
    localparam logic [1:0] c_SRCB_IMM    = 2'b10;
    localparam logic [1:0] c_SRCB_IMM_SH = 2'b11;

    // PC source select
    localparam logic [1:0] c_PCSRC_ALU    = 2'b00;
    localparam logic [1:0] c_PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] c_PCSRC_JUMP   = 2'b10;

    // ALU-op code handed to the ALU-control decoder {aluop1, aluop0}
    localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
    localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
    localparam logic [1:0] c_ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsource;
        logic       illegal_op;
    } ctrl_word_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        logic r_legal;
        case (op)
            c_OP_RTYPE, c_OP_LW, c_OP_SW,
            c_OP_BEQ, c_OP_J, c_OP_ADDI: r_legal = 1'b1;
            default:                     r_legal = 1'b0;
        endcase
        return r_legal;
    endfunction

endpackage : mc_ctrl_pkg
`default_nettype wire

// File: rtl/mc_ctrl_decode.sv
`default_nettype none
// ============================================================================
//  Module      : mc_ctrl_decode
//  Description : Pure combinational state -> control-word decoder for the
//                multicycle MIPS main control.
//  Ports       : i_state     current FSM state
//                i_mem_ready memory handshake (gates FETCH IR/PC writes)
//                i_opcode    opcode (only used to flag illegal in DECODE)
//                o_ctrl      decoded control word
//  Revision    : 1.0  initial release
// ============================================================================
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [c_STATE_W-1:0] i_state,
    input  logic                 i_mem_ready,
    input  logic [5:0]           i_opcode,
    output ctrl_word_t           o_ctrl
);

    always_comb begin
        // Every field not named below is 0 in that state; unreachable
        // encodings fall through to the all-zero word.
        o_ctrl = '0;
        case (i_state)
            c_ST_FETCH: begin
                o_ctrl.memread  = 1'b1;
                o_ctrl.iord     = 1'b0;
                o_ctrl.alusrcb  = c_SRCB_FOUR;
                o_ctrl.aluop    = c_ALUOP_ADD;
                o_ctrl.pcsource = c_PCSRC_ALU;
                // IR load and PC+4 commit only on the cycle the read lands
                o_ctrl.irwrite  = i_mem_ready;
                o_ctrl.pcwrite  = i_mem_ready;
            end
            c_ST_DECODE: begin
                o_ctrl.alusrcb    = c_SRCB_IMM_SH;
                o_ctrl.aluop      = c_ALUOP_ADD;
                o_ctrl.illegal_op = ~is_legal_op(i_opcode);
            end
            c_ST_MEMADR: begin
                o_ctrl.alusrca = 1'b1;
                o_ctrl.alusrcb = c_SRCB_IMM;
                o_ctrl.aluop   = c_ALUOP_ADD;
            end
            c_ST_MEMRD: begin
                o_ctrl.memread = 1'b1;
                o_ctrl.iord    = 1'b1;
            end
            c_ST_MEMWB: begin
                o_ctrl.regwrite = 1'b1;
                o_ctrl.memtoreg = 1'b1;
                o_ctrl.regdst   = 1'b0;
            end
            c_ST_MEMWR: begin
                o_ctrl.memwrite = 1'b1;
                o_ctrl.iord     = 1'b1;
            end
            c_ST_EXEC: begin
                o_ctrl.alusrca = 1'b1;
                o_ctrl.alusrcb = c_SRCB_B;
                o_ctrl.aluop   = c_ALUOP_FUNCT;
            end
            c_ST_RWB: begin
                o_ctrl.regwrite = 1'b1;
                o_ctrl.regdst   = 1'b1;
                o_ctrl.memtoreg = 1'b0;
            end
            c_ST_BRANCH: begin
                o_ctrl.alusrca     = 1'b1;
                o_ctrl.alusrcb     = c_SRCB_B;
                o_ctrl.aluop       = c_ALUOP_SUB;
                o_ctrl.pcwritecond = 1'b1;
                o_ctrl.pcsource    = c_PCSRC_ALUOUT;
            end
            c_ST_JUMP: begin
                o_ctrl.pcwrite  = 1'b1;
                o_ctrl.pcsource = c_PCSRC_JUMP;
            end
            c_ST_ADDIEX: begin
                o_ctrl.alusrca = 1'b1;
                o_ctrl.alusrcb = c_SRCB_IMM;
                o_ctrl.aluop   = c_ALUOP_ADD;
            end
            c_ST_ADDIWB: begin
                o_ctrl.regwrite = 1'b1;
                o_ctrl.regdst   = 1'b0;
                o_ctrl.memtoreg = 1'b0;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule : mc_ctrl_decode
`default_nettype wire

// File: rtl/mc_main_control.sv
`default_nettype none
// ============================================================================
//  Module      : mc_main_control
//  Description : Multicycle MIPS main control FSM with memory-ready
//                handshake. Holds the state register and next-state logic;
//                control outputs come from mc_ctrl_decode.
//  Ports       : clk, rst_n (async, active low)
//                opcode, mem_ready               inputs
//                pcwrite .. pcsource, illegal_op datapath controls
//                state                           current state (debug)
//  Revision    : 1.0  initial release
// ============================================================================
module mc_main_control
    import mc_ctrl_pkg::*;
#(
    parameter int STATE_W = 4   // must be >= 4; wider values zero-extend
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               pcwrite,
    output logic               pcwritecond,
    output logic               iord,
    output logic               memread,
    output logic               memwrite,
    output logic               irwrite,
    output logic               memtoreg,
    output logic               regdst,
    output logic               regwrite,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic               aluop1,
    output logic               aluop0,
    output logic [1:0]         pcsource,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_next_state;
    ctrl_word_t           w_ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = c_ST_FETCH;
        case (r_state)
            c_ST_FETCH:  w_next_state = mem_ready ? c_ST_DECODE : c_ST_FETCH;
            c_ST_DECODE: begin
                case (opcode)
                    c_OP_LW, c_OP_SW: w_next_state = c_ST_MEMADR;
                    c_OP_RTYPE:       w_next_state = c_ST_EXEC;
                    c_OP_BEQ:         w_next_state = c_ST_BRANCH;
                    c_OP_J:           w_next_state = c_ST_JUMP;
                    c_OP_ADDI:        w_next_state = c_ST_ADDIEX;
                    default:          w_next_state = c_ST_FETCH;
                endcase
            end
            // Only LW/SW reach here; anything but SW is treated as a load.
            c_ST_MEMADR: w_next_state = (opcode == c_OP_SW) ? c_ST_MEMWR
                                                            : c_ST_MEMRD;
            c_ST_MEMRD:  w_next_state = mem_ready ? c_ST_MEMWB : c_ST_MEMRD;
            c_ST_MEMWB:  w_next_state = c_ST_FETCH;
            c_ST_MEMWR:  w_next_state = mem_ready ? c_ST_FETCH : c_ST_MEMWR;
            c_ST_EXEC:   w_next_state = c_ST_RWB;
            c_ST_RWB:    w_next_state = c_ST_FETCH;
            c_ST_BRANCH: w_next_state = c_ST_FETCH;
            c_ST_JUMP:   w_next_state = c_ST_FETCH;
            c_ST_ADDIEX: w_next_state = c_ST_ADDIWB;
            c_ST_ADDIWB: w_next_state = c_ST_FETCH;
            default:     w_next_state = c_ST_FETCH;
        endcase
    end

    mc_ctrl_decode u_decode (
        .i_state     (r_state),
        .i_mem_ready (mem_ready),
        .i_opcode    (opcode),
        .o_ctrl      (w_ctrl)
    );

    // Write enables are qualified by rst_n so they drop the instant reset
    // asserts, without waiting for the state register to settle.
    assign pcwrite     = w_ctrl.pcwrite     & rst_n;
    assign pcwritecond = w_ctrl.pcwritecond & rst_n;
    assign irwrite     = w_ctrl.irwrite     & rst_n;
    assign regwrite    = w_ctrl.regwrite    & rst_n;
    assign memwrite    = w_ctrl.memwrite    & rst_n;
    assign illegal_op  = w_ctrl.illegal_op  & rst_n;

    assign iord        = w_ctrl.iord;
    assign memread     = w_ctrl.memread;
    assign memtoreg    = w_ctrl.memtoreg;
    assign regdst      = w_ctrl.regdst;
    assign alusrca     = w_ctrl.alusrca;
    assign alusrcb     = w_ctrl.alusrcb;
    assign aluop1      = w_ctrl.aluop[1];
    assign aluop0      = w_ctrl.aluop[0];
    assign pcsource    = w_ctrl.pcsource;

    assign state       = STATE_W'(r_state);

endmodule : mc_main_control
`default_nettype wire

// File: doc/mc_main_control.md
Name: mc_main_control

Overview:
- Multicycle main control FSM for the MIPS datapath.
- Sits directly upstream of the ALU-control decoder and drives its aluop1/aluop0 inputs.
- Also drives every datapath mux select and write enable. Sequences each instruction through FETCH/DECODE/execute/memory/writeback states.
- Adds a memory-ready handshake so memory states can stall.

Parameters:
- STATE_W, 4, width of state register / debug state output

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  instr[31:26] from instruction register
- mem_ready  in  1  memory completes current access this cycle
- pcwrite  out  1  unconditional PC write
- pcwritecond  out  1  PC write if ALU zero (beq)
- iord  out  1  0=PC, 1=ALUOut as memory address
- memread  out  1  memory read request
- memwrite  out  1  memory write request
- irwrite  out  1  load instruction register
- memtoreg  out  1  1=MDR, 0=ALUOut to register file
- regdst  out  1  1=rd, 0=rt
- regwrite  out  1  register file write
- alusrca  out  1  0=PC, 1=A
- alusrcb  out  2  00=B, 01=4, 10=signext, 11=signext<<2
- aluop1  out  1  to ALU-control decoder
- aluop0  out  1  to ALU-control decoder
- pcsource  out  2  00=ALU, 01=ALUOut, 10=jump target
- illegal_op  out  1  one-cycle pulse on unsupported opcode
- state  out  STATE_W  current state (debug)

Behaviour:
- Opcodes:
  - RTYPE 000000
  - LW 100011
  - SW 101011
  - BEQ 000100
  - J 000010
  - ADDI 001000
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RWB, BRANCH, JUMP, ADDIEX, ADDIWB.
- Outputs are Moore: decoded from the state register only, except where gated by mem_ready as noted.
- Unlisted outputs are 0 in every state.
- rst_n low (async):
  - state <= FETCH.
  - All write enables (pcwrite, pcwritecond, irwrite, regwrite, memwrite) and illegal_op forced 0 while rst_n low.
  - Other outputs show the FETCH decode.
- FETCH:
  - Drives memread=1, alusrcb=01, aluop=00, pcsource=00, iord=0.
  - irwrite=pcwrite=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Drives alusrcb=11, aluop=00.
  - Next state by opcode: LW/SW->MEMADR, RTYPE->EXEC, BEQ->BRANCH, J->JUMP, ADDI->ADDIEX.
  - Any other opcode: illegal_op=1 this cycle, next FETCH.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Next MEMRD if LW, MEMWR if SW.
- MEMRD:
  - Drives memread=1, iord=1.
  - Holds until mem_ready=1, then MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0. Next FETCH.
- MEMWR:
  - Drives memwrite=1, iord=1.
  - Holds until mem_ready=1, then FETCH.
  - memwrite stays high for the whole hold.
- EXEC: alusrca=1, alusrcb=00, aluop=10. Next RWB.
- RWB: regwrite=1, regdst=1, memtoreg=0. Next FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsource=01. Next FETCH.
- JUMP: pcwrite=1, pcsource=10. Next FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. Next ADDIWB.
- ADDIWB: regwrite=1, regdst=0, memtoreg=0. Next FETCH.
- Cycles per instruction with mem_ready tied 1: LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3.
- Each memory wait cycle adds exactly 1 cycle.
- Unreachable state encodings: next state FETCH, all write enables 0.
- Opcode is sampled only in DECODE and MEMADR. Opcode changes in other states are ignored.
- Reset asserted mid-instruction: immediate return to FETCH, no further writes. A pending memwrite drops asynchronously.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state encodings (localparams, STATE_W bits)
  - opcode constants
  - alusrcb / pcsource / aluop encodings
- One sub-module is natural: mc_ctrl_decode, a pure combinational state->control-word decoder. The top keeps the state register and next-state logic.

Test Plan:
- Reset and fetch: hold rst_n=0 3 cycles, mem_ready=1 -> state=FETCH and all write enables 0. After release, cycle 1 gives irwrite=pcwrite=1, aluop=00; next state DECODE.
- LW: opcode=100011, mem_ready=1 -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB,FETCH. regwrite=1 and memtoreg=1 only in MEMWB.
- R-type: opcode=000000 -> aluop1=1/aluop0=0 in EXEC, regwrite=1 with regdst=1 in RWB, 4 cycles total. BEQ=000100 -> aluop0=1, pcwritecond=1 in BRANCH, 3 cycles total.
- Memory stall: SW with mem_ready low 3 cycles in MEMWR -> memwrite held 4 cycles, state stays MEMWR, then FETCH. Also cover FETCH stall: irwrite stays 0 until mem_ready=1.
- Illegal opcode 111111 -> illegal_op=1 for exactly 1 cycle in DECODE, then FETCH, with no regwrite/memwrite/pcwrite.
- Async reset mid-MEMWR: rst_n falls between clock edges -> memwrite=0 immediately, state=FETCH before the next edge.
